// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// State encodings are visible on the LED debug bus.
package alu_seq_pkg;

  localparam int STATE_W   = 3;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_OP_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    ISSUE  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/key_edge_sync.sv
// Synchroniser chain for an async key plus rising-edge detector.
// Emits one pulse per 0->1 of the synchronised level.
module key_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // shift the raw level in and keep last synced level
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode over three key presses, then issues them.
// Define ALU_SEQ_CHAIN_EN to feed the result back as the next A.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int OP_W        = DEF_OP_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               enter,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [OP_W-1:0]    op_in,
  input  logic [2*WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0]   operand_a,
  output logic [WIDTH-1:0]   operand_b,
  output logic [OP_W-1:0]    opcode,
  output logic               alu_valid,
  output logic [2*WIDTH-1:0] result_reg,
  output logic               done,
  output logic [2:0]         state_dbg
);

  state_t state_q;
  state_t state_d;
  logic   enter_pulse;
  logic   ld_a;
  logic   ld_b;
  logic   ld_op;
  logic   ld_res;
`ifdef ALU_SEQ_CHAIN_EN
  logic   chain;
`endif

  key_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .resetn(resetn),
    .in    (enter),
    .pulse (enter_pulse)
  );

  // state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= GET_A;
    else         state_q <= state_d;
  end

  // next state and capture enables
  always_comb begin
    state_d = state_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_op   = 1'b0;
    ld_res  = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    chain   = 1'b0;
`endif
    unique case (state_q)
      GET_A: if (enter_pulse) begin
        ld_a    = 1'b1;
        state_d = GET_B;
      end
      GET_B: if (enter_pulse) begin
        ld_b    = 1'b1;
        state_d = GET_OP;
      end
      GET_OP: if (enter_pulse) begin
        ld_op   = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        ld_res  = 1'b1;
        state_d = DONE;
      end
      DONE: if (enter_pulse) begin
`ifdef ALU_SEQ_CHAIN_EN
        ld_a    = 1'b1;
        chain   = 1'b1;
        state_d = GET_B;
`else
        state_d = GET_A;
`endif
      end
      default: state_d = GET_A;
    endcase
  end

  // capture registers, each written only by its own enable
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      operand_a  <= '0;
      operand_b  <= '0;
      opcode     <= '0;
      result_reg <= '0;
    end else begin
`ifdef ALU_SEQ_CHAIN_EN
      if (ld_a)
        operand_a <= chain ? result_reg[WIDTH-1:0]
                           : data_in;
`else
      if (ld_a)   operand_a  <= data_in;
`endif
      if (ld_b)   operand_b  <= data_in;
      if (ld_op)  opcode     <= op_in;
      if (ld_res) result_reg <= alu_result;
    end
  end

  assign alu_valid = (state_q == ISSUE);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer.
// Expected values are hand-computed per scenario.
module tb_alu_operand_sequencer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       enter = 1'b0;
  logic [3:0] data_in = '0;
  logic [2:0] op_in = '0;
  logic [7:0] alu_result;
  logic [3:0] operand_a;
  logic [3:0] operand_b;
  logic [2:0] opcode;
  logic       alu_valid;
  logic [7:0] result_reg;
  logic       done;
  logic [2:0] state_dbg;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  function automatic logic [7:0] alu_model(
    input logic [3:0] a, input logic [3:0] b,
    input logic [2:0] op);
    case (op)
      3'b001:  alu_model = {4'h0, a} + {4'h0, b};
      3'b010:  alu_model = {4'h0, a} * {4'h0, b};
      default: alu_model = {a, b};
    endcase
  endfunction

  assign alu_result = alu_model(operand_a, operand_b, opcode);

  alu_operand_sequencer dut (
    .clock     (clock),
    .resetn    (resetn),
    .enter     (enter),
    .data_in   (data_in),
    .op_in     (op_in),
    .alu_result(alu_result),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .opcode    (opcode),
    .alu_valid (alu_valid),
    .result_reg(result_reg),
    .done      (done),
    .state_dbg (state_dbg)
  );

  task automatic do_reset();
    @(negedge clock);
    enter  = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic press(input logic [3:0] d, input logic [2:0] op);
    @(negedge clock);
    data_in = d;
    op_in   = op;
    enter   = 1'b1;
    repeat (3) @(negedge clock);
    enter = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state_dbg, operand_a, operand_b, opcode,
         result_reg, alu_valid, done} !== 24'h0)
      $display("FAIL reset: got st=%0d a=%h b=%h op=%h r=%h v=%b d=%b want all 0",
               state_dbg, operand_a, operand_b, opcode,
               result_reg, alu_valid, done);
    else passes++;
  endtask

  task automatic test_basic();
    do_reset();
    press(4'h3, 3'b000);
    checks++;
    if (state_dbg !== 3'd1 || operand_a !== 4'h3)
      $display("FAIL cap_a: got st=%0d a=%h want st=1 a=3",
               state_dbg, operand_a);
    else passes++;
    press(4'h5, 3'b000);
    checks++;
    if (state_dbg !== 3'd2 || operand_b !== 4'h5)
      $display("FAIL cap_b: got st=%0d b=%h want st=2 b=5",
               state_dbg, operand_b);
    else passes++;
    @(negedge clock);
    op_in = 3'b001;
    enter = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (state_dbg !== 3'd2 || alu_valid !== 1'b0)
      $display("FAIL op_wait: got st=%0d v=%b want st=2 v=0",
               state_dbg, alu_valid);
    else passes++;
    @(posedge clock);
    #1;
    checks++;
    if (state_dbg !== 3'd3 || alu_valid !== 1'b1 ||
        opcode !== 3'b001 || result_reg !== 8'h00)
      $display("FAIL issue: got st=%0d v=%b op=%b r=%h want st=3 v=1 op=001 r=00",
               state_dbg, alu_valid, opcode, result_reg);
    else passes++;
    @(posedge clock);
    #1;
    checks++;
    if (state_dbg !== 3'd4 || alu_valid !== 1'b0 ||
        done !== 1'b1 || result_reg !== 8'h08)
      $display("FAIL done: got st=%0d v=%b d=%b r=%h want st=4 v=0 d=1 r=08",
               state_dbg, alu_valid, done, result_reg);
    else passes++;
    @(negedge clock);
    enter = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (state_dbg !== 3'd4 || result_reg !== 8'h08)
      $display("FAIL done_hold: got st=%0d r=%h want st=4 r=08",
               state_dbg, result_reg);
    else passes++;
  endtask

  task automatic test_hold();
    do_reset();
    @(negedge clock);
    data_in = 4'hA;
    enter   = 1'b1;
    repeat (20) @(negedge clock);
    checks++;
    if (state_dbg !== 3'd1 || operand_a !== 4'hA ||
        operand_b !== 4'h0)
      $display("FAIL hold: got st=%0d a=%h b=%h want st=1 a=A b=0",
               state_dbg, operand_a, operand_b);
    else passes++;
    enter = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_issue_drop();
    do_reset();
    press(4'h2, 3'b000);
    press(4'h7, 3'b000);
    @(negedge clock);
    data_in = 4'h9;
    op_in   = 3'b010;
    enter   = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (state_dbg !== 3'd3)
      $display("FAIL drop_pre: got st=%0d want 3", state_dbg);
    else passes++;
    force dut.enter_pulse = 1'b1;
    @(posedge clock);
    #1;
    release dut.enter_pulse;
    enter = 1'b0;
    checks++;
    if (state_dbg !== 3'd4 || operand_a !== 4'h2 ||
        operand_b !== 4'h7 || opcode !== 3'b010 ||
        result_reg !== 8'h0E)
      $display("FAIL drop: got st=%0d a=%h b=%h op=%b r=%h want st=4 a=2 b=7 op=010 r=0E",
               state_dbg, operand_a, operand_b, opcode, result_reg);
    else passes++;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset_issue();
    do_reset();
    press(4'h4, 3'b000);
    press(4'h6, 3'b000);
    @(negedge clock);
    op_in = 3'b001;
    enter = 1'b1;
    repeat (3) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if ({state_dbg, operand_a, operand_b, opcode,
         result_reg, alu_valid, done} !== 24'h0)
      $display("FAIL rst_issue: got st=%0d a=%h b=%h op=%h r=%h v=%b want all 0",
               state_dbg, operand_a, operand_b, opcode,
               result_reg, alu_valid);
    else passes++;
    enter = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (state_dbg !== 3'd0 || result_reg !== 8'h00)
      $display("FAIL rst_after: got st=%0d r=%h want st=0 r=00",
               state_dbg, result_reg);
    else passes++;
  endtask

  task automatic test_done_press();
    do_reset();
    press(4'hE, 3'b000);
    press(4'hE, 3'b000);
    press(4'h0, 3'b001);
    checks++;
    if (state_dbg !== 3'd4 || result_reg !== 8'h1C)
      $display("FAIL chain_res: got st=%0d r=%h want st=4 r=1C",
               state_dbg, result_reg);
    else passes++;
    press(4'h5, 3'b000);
`ifdef ALU_SEQ_CHAIN_EN
    checks++;
    if (state_dbg !== 3'd1 || operand_a !== 4'hC)
      $display("FAIL chain_a: got st=%0d a=%h want st=1 a=C",
               state_dbg, operand_a);
    else passes++;
`else
    checks++;
    if (state_dbg !== 3'd0 || operand_a !== 4'hE)
      $display("FAIL nochain: got st=%0d a=%h want st=0 a=E",
               state_dbg, operand_a);
    else passes++;
    press(4'h5, 3'b000);
    checks++;
    if (state_dbg !== 3'd1 || operand_a !== 4'h5 ||
        result_reg !== 8'h1C)
      $display("FAIL res_hold: got st=%0d a=%h r=%h want st=1 a=5 r=1C",
               state_dbg, operand_a, result_reg);
    else passes++;
`endif
  endtask

  task automatic test_bad_state();
    do_reset();
    press(4'h1, 3'b000);
    press(4'h2, 3'b000);
    press(4'h0, 3'b000);
    @(negedge clock);
    force dut.state_q = alu_seq_pkg::state_t'(3'd6);
    #1;
    release dut.state_q;
    #1;
    checks++;
    if (state_dbg !== 3'd6)
      $display("FAIL bad_pre: got st=%0d want 6", state_dbg);
    else passes++;
    @(posedge clock);
    #1;
    checks++;
    if (state_dbg !== 3'd0 || operand_a !== 4'h1 ||
        operand_b !== 4'h2 || opcode !== 3'b000 ||
        result_reg !== 8'h12)
      $display("FAIL bad_state: got st=%0d a=%h b=%h op=%b r=%h want st=0 a=1 b=2 op=000 r=12",
               state_dbg, operand_a, operand_b, opcode, result_reg);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_issue_drop();
    test_reset_issue();
    test_done_press();
    test_bad_state();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
